// File: rtl/gpr_pkg.sv
// Shared types and sizes for the general-purpose register file.
// Bit 0 is the MSB of every address and data word (big-endian numbering).
package gpr_pkg;

    localparam int GPR_NREGS = 32;
    localparam int GPR_AW    = 5;
    localparam int GPR_DW    = 64;

    typedef logic [0:GPR_AW-1] gpr_addr_t;
    typedef logic [0:GPR_DW-1] gpr_data_t;

endpackage

// File: rtl/gpr_regfile_if.sv
// Read/write port bundle between the pipeline and the register file.
// Ports: read ports 0/1 (enable, address, registered data) and
//        write ports 0/1 (enable, address, data).
// master: pipeline side (Decode drives reads, Writeback drives writes).
// slave:  register file side.
interface gpr_regfile_if;
    import gpr_pkg::*;

    logic      rd_en0;
    gpr_addr_t rd_addr0;
    gpr_data_t rd_data0;
    logic      rd_en1;
    gpr_addr_t rd_addr1;
    gpr_data_t rd_data1;

    logic      wr_en0;
    gpr_addr_t wr_addr0;
    gpr_data_t wr_data0;
    logic      wr_en1;
    gpr_addr_t wr_addr1;
    gpr_data_t wr_data1;

    modport master (
        output rd_en0, rd_addr0, rd_en1, rd_addr1,
        output wr_en0, wr_addr0, wr_data0,
        output wr_en1, wr_addr1, wr_data1,
        input  rd_data0, rd_data1
    );

    modport slave (
        input  rd_en0, rd_addr0, rd_en1, rd_addr1,
        input  wr_en0, wr_addr0, wr_data0,
        input  wr_en1, wr_addr1, wr_data1,
        output rd_data0, rd_data1
    );

endinterface

// File: rtl/gpr_read_port.sv
// One registered read port: selects a register and captures it on clk.
// Ports: clk, rst_n (sync, active-low), rd_en, rd_addr, regs (storage
//        array), rd_data (registered); with GPR_WRITE_BYPASS_EN defined
//        the two write ports are also inputs so a same-edge write to the
//        read address is captured instead of the old contents.
module gpr_read_port
    import gpr_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rd_en,
    input  gpr_addr_t rd_addr,
    input  gpr_data_t regs [GPR_NREGS],
`ifdef GPR_WRITE_BYPASS_EN
    input  logic      wr_en0,
    input  gpr_addr_t wr_addr0,
    input  gpr_data_t wr_data0,
    input  logic      wr_en1,
    input  gpr_addr_t wr_addr1,
    input  gpr_data_t wr_data1,
`endif
    output gpr_data_t rd_data
);

    gpr_data_t next_data;

    always_comb begin
        next_data = regs[rd_addr];
`ifdef GPR_WRITE_BYPASS_EN
        // Port 1 checked last so it wins, matching storage priority.
        if (wr_en0 && (wr_addr0 == rd_addr)) begin
            next_data = wr_data0;
        end
        if (wr_en1 && (wr_addr1 == rd_addr)) begin
            next_data = wr_data1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= next_data;
        end
    end

endmodule

// File: rtl/gpr_regfile.sv
// 32 x 64-bit register file: two registered read ports, two write ports.
// Ports: clk, rst_n (sync, active-low), bus (gpr_regfile_if.slave).
// Optional macro GPR_WRITE_BYPASS_EN makes reads write-through;
// without it a same-edge read returns the old register contents.
module gpr_regfile
    import gpr_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    gpr_regfile_if.slave  bus
);

    gpr_data_t regs [GPR_NREGS];

    // Port 1 assigned last: on an address collision its data wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < GPR_NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (bus.wr_en0) begin
                regs[bus.wr_addr0] <= bus.wr_data0;
            end
            if (bus.wr_en1) begin
                regs[bus.wr_addr1] <= bus.wr_data1;
            end
        end
    end

    gpr_read_port u_rd0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (bus.rd_en0),
        .rd_addr  (bus.rd_addr0),
        .regs     (regs),
`ifdef GPR_WRITE_BYPASS_EN
        .wr_en0   (bus.wr_en0),
        .wr_addr0 (bus.wr_addr0),
        .wr_data0 (bus.wr_data0),
        .wr_en1   (bus.wr_en1),
        .wr_addr1 (bus.wr_addr1),
        .wr_data1 (bus.wr_data1),
`endif
        .rd_data  (bus.rd_data0)
    );

    gpr_read_port u_rd1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (bus.rd_en1),
        .rd_addr  (bus.rd_addr1),
        .regs     (regs),
`ifdef GPR_WRITE_BYPASS_EN
        .wr_en0   (bus.wr_en0),
        .wr_addr0 (bus.wr_addr0),
        .wr_data0 (bus.wr_data0),
        .wr_en1   (bus.wr_en1),
        .wr_addr1 (bus.wr_addr1),
        .wr_data1 (bus.wr_data1),
`endif
        .rd_data  (bus.rd_data1)
    );

endmodule

// File: tb/tb_gpr_regfile.sv
// Directed self-checking bench for gpr_regfile.
// Honours GPR_WRITE_BYPASS_EN for the same-edge read/write case.
module tb_gpr_regfile;
    import gpr_pkg::*;

    logic clk;
    logic rst_n;
    int   n_run;
    int   n_fail;

    gpr_regfile_if bus ();

    gpr_regfile dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam gpr_data_t PAT5 = 64'h0123456789ABCDEF;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd_en0   = 1'b0;
        bus.rd_en1   = 1'b0;
        bus.wr_en0   = 1'b0;
        bus.wr_en1   = 1'b0;
        bus.rd_addr0 = '0;
        bus.rd_addr1 = '0;
        bus.wr_addr0 = '0;
        bus.wr_addr1 = '0;
        bus.wr_data0 = '0;
        bus.wr_data1 = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        n_run++;
        if (bus.rd_data0 !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rd0 got %h exp 0", bus.rd_data0);
        end
        n_run++;
        if (bus.rd_data1 !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rd1 got %h exp 0", bus.rd_data1);
        end
        rst_n = 1'b1;
        for (int a = 0; a < GPR_NREGS; a++) begin
            bus.rd_en0   = 1'b1;
            bus.rd_en1   = 1'b1;
            bus.rd_addr0 = gpr_addr_t'(a);
            bus.rd_addr1 = gpr_addr_t'(GPR_NREGS - 1 - a);
            tick();
            n_run++;
            if (bus.rd_data0 !== 64'h0 || bus.rd_data1 !== 64'h0) begin
                n_fail++;
                $display("FAIL reset_clear a=%0d got %h/%h exp 0/0",
                         a, bus.rd_data0, bus.rd_data1);
            end
        end
        idle();
    endtask

    task automatic test_basic();
        bus.wr_en0   = 1'b1;
        bus.wr_addr0 = 5'd5;
        bus.wr_data0 = PAT5;
        tick();
        idle();
        bus.rd_en1   = 1'b1;
        bus.rd_addr1 = 5'd5;
        bus.rd_en0   = 1'b1;
        bus.rd_addr0 = 5'd4;
        tick();
        n_run++;
        if (bus.rd_data1 !== PAT5) begin
            n_fail++;
            $display("FAIL basic_r5 got %h exp %h", bus.rd_data1, PAT5);
        end
        n_run++;
        if (bus.rd_data0 !== 64'h0) begin
            n_fail++;
            $display("FAIL basic_r4 got %h exp 0", bus.rd_data0);
        end
        idle();
    endtask

    task automatic test_dual_write();
        bus.wr_en0   = 1'b1;
        bus.wr_addr0 = 5'd7;
        bus.wr_data0 = 64'h11;
        bus.wr_en1   = 1'b1;
        bus.wr_addr1 = 5'd8;
        bus.wr_data1 = 64'h22;
        tick();
        bus.wr_addr0 = 5'd9;
        bus.wr_data0 = 64'hAA;
        bus.wr_addr1 = 5'd9;
        bus.wr_data1 = 64'hBB;
        tick();
        idle();
        bus.rd_en0   = 1'b1;
        bus.rd_addr0 = 5'd7;
        bus.rd_en1   = 1'b1;
        bus.rd_addr1 = 5'd8;
        tick();
        n_run++;
        if (bus.rd_data0 !== 64'h11) begin
            n_fail++;
            $display("FAIL dual_r7 got %h exp 11", bus.rd_data0);
        end
        n_run++;
        if (bus.rd_data1 !== 64'h22) begin
            n_fail++;
            $display("FAIL dual_r8 got %h exp 22", bus.rd_data1);
        end
        bus.rd_addr0 = 5'd9;
        bus.rd_addr1 = 5'd9;
        tick();
        n_run++;
        if (bus.rd_data0 !== 64'hBB || bus.rd_data1 !== 64'hBB) begin
            n_fail++;
            $display("FAIL wr_collision_r9 got %h/%h exp bb/bb",
                     bus.rd_data0, bus.rd_data1);
        end
        idle();
    endtask

    task automatic test_read_before_write();
        gpr_data_t exp_same;
`ifdef GPR_WRITE_BYPASS_EN
        exp_same = 64'h6;
`else
        exp_same = 64'h5;
`endif
        bus.wr_en0   = 1'b1;
        bus.wr_addr0 = 5'd3;
        bus.wr_data0 = 64'h5;
        tick();
        bus.wr_data0 = 64'h6;
        bus.rd_en0   = 1'b1;
        bus.rd_addr0 = 5'd3;
        tick();
        n_run++;
        if (bus.rd_data0 !== exp_same) begin
            n_fail++;
            $display("FAIL rbw_same_edge got %h exp %h",
                     bus.rd_data0, exp_same);
        end
        bus.wr_en0 = 1'b0;
        tick();
        n_run++;
        if (bus.rd_data0 !== 64'h6) begin
            n_fail++;
            $display("FAIL rbw_next got %h exp 6", bus.rd_data0);
        end
        idle();
    endtask

    task automatic test_enable_hold();
        bus.rd_en0   = 1'b1;
        bus.rd_addr0 = 5'd5;
        tick();
        n_run++;
        if (bus.rd_data0 !== PAT5) begin
            n_fail++;
            $display("FAIL hold_load got %h exp %h", bus.rd_data0, PAT5);
        end
        bus.rd_en0   = 1'b0;
        bus.rd_addr0 = 5'd0;
        tick();
        tick();
        n_run++;
        if (bus.rd_data0 !== PAT5) begin
            n_fail++;
            $display("FAIL hold_keep got %h exp %h", bus.rd_data0, PAT5);
        end
        idle();
    endtask

    task automatic test_sync_reset();
        bus.wr_en0   = 1'b1;
        bus.wr_addr0 = 5'd1;
        bus.wr_data0 = 64'hFF;
        tick();
        idle();
        bus.rd_en0   = 1'b1;
        bus.rd_addr0 = 5'd1;
        bus.rd_en1   = 1'b1;
        bus.rd_addr1 = 5'd5;
        tick();
        n_run++;
        if (bus.rd_data0 !== 64'hFF || bus.rd_data1 !== PAT5) begin
            n_fail++;
            $display("FAIL srst_pre got %h/%h exp ff/%h",
                     bus.rd_data0, bus.rd_data1, PAT5);
        end
        @(negedge clk);
        rst_n        = 1'b0;
        bus.wr_en0   = 1'b1;
        bus.wr_addr0 = 5'd2;
        bus.wr_data0 = 64'h33;
        #2;
        n_run++;
        if (bus.rd_data0 !== 64'hFF || bus.rd_data1 !== PAT5) begin
            n_fail++;
            $display("FAIL srst_no_edge got %h/%h exp ff/%h",
                     bus.rd_data0, bus.rd_data1, PAT5);
        end
        tick();
        n_run++;
        if (bus.rd_data0 !== 64'h0 || bus.rd_data1 !== 64'h0) begin
            n_fail++;
            $display("FAIL srst_out got %h/%h exp 0/0",
                     bus.rd_data0, bus.rd_data1);
        end
        rst_n        = 1'b1;
        bus.wr_en0   = 1'b0;
        bus.rd_addr0 = 5'd1;
        bus.rd_addr1 = 5'd2;
        tick();
        n_run++;
        if (bus.rd_data0 !== 64'h0 || bus.rd_data1 !== 64'h0) begin
            n_fail++;
            $display("FAIL srst_regs got %h/%h exp 0/0",
                     bus.rd_data0, bus.rd_data1);
        end
        idle();
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_dual_write();
        test_read_before_write();
        test_enable_hold();
        test_sync_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
